// File: rtl/multi_voice_audio_engine.sv
// multi_voice_audio_engine: N-voice tone synthesiser.
// Each voice has a phase accumulator, a square/saw waveform and an amplitude.
// The voice samples are summed into a registered mix word. A first-order
// sigma-delta modulator turns the mix into a 1-bit audio stream.
// Optional feature macro: NOISE_VOICE_EN adds a 16-bit Galois LFSR noise
// source for wave==2. When the macro is undefined, wave==2 is silent.
module multi_voice_audio_engine #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int AMP_W      = 4,
  parameter int SAMPLE_DIV = 256,
  localparam int VID_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int MIX_W     = AMP_W + ((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 0)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [VID_W-1:0]   cfg_voice,
  input  logic [PHASE_W-1:0] cfg_incr,
  input  logic [AMP_W-1:0]   cfg_amp,
  input  logic [1:0]         cfg_wave,
  input  logic               cfg_prst,
  output logic               cfg_err,
  output logic               sample_tick,
  output logic [MIX_W-1:0]   mix,
  output logic               audio
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0] cnt_reg;
  logic             tick_d_reg;
  logic             ready_reg;
  logic             err_reg;
  logic [MIX_W-1:0] mix_reg;
  logic [MIX_W-1:0] acc_reg;
  logic             audio_reg;
  logic [MIX_W-1:0] mix_next;
  logic             cfg_fire;
  logic             voice_ok;
  logic [AMP_W-1:0] sample [NUM_VOICES];

  assign cfg_fire    = cfg_valid & ready_reg;
  assign voice_ok    = ({1'b0, cfg_voice} < (VID_W + 1)'(NUM_VOICES));
  assign sample_tick = (cnt_reg == CNT_W'(SAMPLE_DIV - 1));
  assign cfg_ready   = ready_reg;
  assign cfg_err     = err_reg;
  assign mix         = mix_reg;
  assign audio       = audio_reg;

`ifdef NOISE_VOICE_EN
  logic [15:0] lfsr_reg;

  // Noise source: right-shifting Galois LFSR, taps 16,15,13,4, stepped once per sample tick
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= 16'hACE1;
    end else if (sample_tick) begin
      lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hD008 : 16'h0000);
    end
  end
`endif

  // Sample-rate prescaler, handshake readiness and bad-index error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      tick_d_reg <= 1'b0;
      ready_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      cnt_reg    <= sample_tick ? '0 : cnt_reg + 1'b1;
      tick_d_reg <= sample_tick;
      ready_reg  <= 1'b1;
      err_reg    <= cfg_fire & ~voice_ok;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic [PHASE_W-1:0] phase_reg;
      logic [PHASE_W-1:0] incr_reg;
      logic [AMP_W-1:0]   amp_reg;
      logic [1:0]         wave_reg;
      logic [AMP_W-1:0]   voice_sample;
      logic               sel;

      assign sel = cfg_fire & voice_ok & (cfg_voice == VID_W'(gi));

      // Phase accumulation uses the incr already held; a same-edge write only lands for the next tick
      always_ff @(posedge clk) begin
        if (rst) begin
          phase_reg <= '0;
          incr_reg  <= '0;
          amp_reg   <= '0;
          wave_reg  <= 2'd0;
        end else begin
          if (sel && cfg_prst) begin
            phase_reg <= '0;
          end else if (sample_tick) begin
            phase_reg <= phase_reg + incr_reg;
          end
          if (sel) begin
            incr_reg <= cfg_incr;
            amp_reg  <= cfg_amp;
            wave_reg <= cfg_wave;
          end
        end
      end

      // Waveform shaping from the current voice registers; saw keeps the top AMP_W bits of phase*amp
      always_comb begin
        voice_sample = '0;
        if (amp_reg != '0) begin
          case (wave_reg)
            2'd0: voice_sample = phase_reg[PHASE_W-1] ? '0 : amp_reg;
            2'd1: voice_sample = AMP_W'(({{AMP_W{1'b0}}, phase_reg[PHASE_W-1 -: AMP_W]} *
                                         {{AMP_W{1'b0}}, amp_reg}) >> AMP_W);
`ifdef NOISE_VOICE_EN
            2'd2: voice_sample = AMP_W'(({{AMP_W{1'b0}}, lfsr_reg[15 -: AMP_W]} *
                                         {{AMP_W{1'b0}}, amp_reg}) >> AMP_W);
`endif
            default: voice_sample = '0;
          endcase
        end
      end

      assign sample[gi] = voice_sample;
    end
  endgenerate

  // Sum of all voices; MIX_W leaves headroom for NUM_VOICES full-scale samples
  always_comb begin
    mix_next = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_next = mix_next + MIX_W'(sample[i]);
    end
  end

  // Mix capture one clock after the tick edge, then first-order sigma-delta every clock
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_reg   <= '0;
      acc_reg   <= '0;
      audio_reg <= 1'b0;
    end else begin
      if (tick_d_reg) begin
        mix_reg <= mix_next;
      end
      {audio_reg, acc_reg} <= {1'b0, acc_reg} + {1'b0, mix_reg};
    end
  end

endmodule
